// File: rtl/key_event_decoder.sv
// Per-key press/release/long-press/auto-repeat event decoder with registered single-cycle pulses.
// Build option: define KEY_EVENT_REPEAT_EN to enable periodic repeat pulses in the long state.
// The release and repeat outputs are named release_pulse and repeat_pulse because "release" and "repeat" are reserved words.
module key_event_decoder #(
    parameter int w             = 1,
    parameter int cnt_w         = 24,
    parameter int long_cycles   = 12_500_000,
    parameter int repeat_cycles = 2_500_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [w-1:0] key_in,
    output logic [w-1:0] press,
    output logic [w-1:0] release_pulse,
    output logic [w-1:0] long_press,
    output logic [w-1:0] repeat_pulse,
    output logic [w-1:0] held
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    // Reject illegal timing parameters at elaboration.
    if (long_cycles < 2 || longint'(long_cycles) >= (longint'(1) << cnt_w)) begin : g_bad_long
        $error("key_event_decoder: long_cycles out of range");
    end
    if (repeat_cycles < 1 || longint'(repeat_cycles) >= (longint'(1) << cnt_w)) begin : g_bad_repeat
        $error("key_event_decoder: repeat_cycles out of range");
    end

    localparam logic [cnt_w-1:0] LONG_TC = cnt_w'(long_cycles - 1);

    state_t           state_q [w];
    state_t           state_d [w];
    logic [cnt_w-1:0] cnt_q   [w];
    logic [cnt_w-1:0] cnt_d   [w];

    logic [w-1:0] press_q, press_d;
    logic [w-1:0] release_q, release_d;
    logic [w-1:0] long_q, long_d;
    logic [w-1:0] repeat_d;
    logic [w-1:0] held_q, held_d;

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [cnt_w-1:0] REPEAT_TC = cnt_w'(repeat_cycles - 1);
    logic [w-1:0] repeat_q;
`endif

    always_comb begin
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        repeat_d  = '0;
        held_d    = '0;
        for (int i = 0; i < w; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (key_in[i]) begin
                        press_d[i] = 1'b1;
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end
                end
                PRESSED: begin
                    if (!key_in[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = IDLE;
                    end else if (cnt_q[i] == LONG_TC) begin
                        long_d[i]  = 1'b1;
                        state_d[i] = LONG;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + cnt_w'(1);
                    end
                end
                LONG: begin
                    if (!key_in[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = IDLE;
                    end else begin
`ifdef KEY_EVENT_REPEAT_EN
                        if (cnt_q[i] == REPEAT_TC) begin
                            repeat_d[i] = 1'b1;
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + cnt_w'(1);
                        end
`else
                        // Counter parks at zero until release.
                        cnt_d[i] = '0;
`endif
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            held_d[i] = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < w; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            held_q    <= '0;
        end else begin
            for (int i = 0; i < w; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeat_q <= '0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = '0;
    logic unused_repeat;
    assign unused_repeat = ^repeat_d;
`endif

    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign held          = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed bench for key_event_decoder against a hold-length event model.
module tb_key_event_decoder;
    localparam int W = 2;
    localparam int L = 8;
    localparam int R = 4;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] key_in = '0;
    logic [W-1:0] press, release_pulse, long_press, repeat_pulse, held;

    int total = 0;
    int bad   = 0;

    // Model: per key, whether held and how many edges since the press edge.
    bit           m_held [W];
    int           m_n    [W];
    logic [W-1:0] e_press, e_rel, e_long, e_rep, e_held;

    key_event_decoder #(
        .w(W), .cnt_w(24), .long_cycles(L), .repeat_cycles(R)
    ) dut (
        .clk(clk), .reset(reset), .key_in(key_in),
        .press(press), .release_pulse(release_pulse), .long_press(long_press),
        .repeat_pulse(repeat_pulse), .held(held)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_held[i] = 1'b0;
            m_n[i]    = 0;
        end
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_held = '0;
    endtask

    task automatic model_edge(input logic [W-1:0] k);
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int i = 0; i < W; i++) begin
            if (!m_held[i]) begin
                if (k[i]) begin
                    e_press[i] = 1'b1;
                    m_held[i]  = 1'b1;
                    m_n[i]     = 1;
                end
            end else if (!k[i]) begin
                e_rel[i]  = 1'b1;
                m_held[i] = 1'b0;
            end else begin
                if (m_n[i] == L) e_long[i] = 1'b1;
                else if (REP_EN && m_n[i] > L && ((m_n[i] - L) % R) == 0) e_rep[i] = 1'b1;
                m_n[i]++;
            end
            e_held[i] = m_held[i];
        end
    endtask

    // Drive one cycle of key levels and advance the model; outputs are stable on return.
    task automatic cyc(input logic [W-1:0] k);
        key_in = k;
        @(posedge clk);
        #1;
        model_edge(k);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({press, release_pulse, long_press, repeat_pulse, held} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {press, release_pulse, long_press, repeat_pulse, held});
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_long_hold();
        int n_long = 0, n_rep = 0, n_rel = 0, long_at = -1;
        int rep_at[$];
        for (int t = 0; t < 32; t++) begin
            cyc((t < 30) ? 2'b01 : 2'b00);
            total++;
            if ({press, release_pulse, long_press, repeat_pulse, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                bad++;
                $display("FAIL long_hold t=%0d got=%b want=%b", t,
                         {press, release_pulse, long_press, repeat_pulse, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
            if (long_press[0]) begin n_long++; long_at = t; end
            if (repeat_pulse[0]) begin n_rep++; rep_at.push_back(t); end
            if (release_pulse[0]) n_rel++;
        end
        total++;
        if (n_long != 1 || long_at != 8) begin
            bad++;
            $display("FAIL long_hold_long count=%0d at=%0d want 1 at 8", n_long, long_at);
        end
        total++;
        if (n_rep != (REP_EN ? 5 : 0)) begin
            bad++;
            $display("FAIL long_hold_repeat_count got=%0d want=%0d", n_rep, REP_EN ? 5 : 0);
        end
        if (REP_EN && n_rep == 5) begin
            total++;
            if (rep_at[0] != 12 || rep_at[4] != 28) begin
                bad++;
                $display("FAIL long_hold_repeat_times first=%0d last=%0d want 12 and 28", rep_at[0], rep_at[4]);
            end
        end
        total++;
        if (n_rel != 1) begin
            bad++;
            $display("FAIL long_hold_release count=%0d want=1", n_rel);
        end
    endtask

    task automatic test_short_hold(input int hold_len, input string name);
        int n_held = 0, n_long = 0, n_rel = 0, n_press = 0;
        for (int t = 0; t < hold_len + 3; t++) begin
            cyc((t < hold_len) ? 2'b01 : 2'b00);
            total++;
            if ({press, release_pulse, long_press, repeat_pulse, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                bad++;
                $display("FAIL %s t=%0d got=%b want=%b", name, t,
                         {press, release_pulse, long_press, repeat_pulse, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
            n_held  += int'(held[0]);
            n_long  += int'(long_press[0]);
            n_rel   += int'(release_pulse[0]);
            n_press += int'(press[0]);
        end
        total++;
        if (n_held != hold_len || n_long != 0 || n_rel != 1 || n_press != 1) begin
            bad++;
            $display("FAIL %s_summary held=%0d long=%0d rel=%0d press=%0d want held=%0d long=0 rel=1 press=1",
                     name, n_held, n_long, n_rel, n_press, hold_len);
        end
    endtask

    task automatic test_two_keys();
        int n_long0 = 0;
        for (int t = 0; t < 14; t++) begin
            cyc((t < 3) ? 2'b11 : (t < 12) ? 2'b01 : 2'b00);
            total++;
            if ({press, release_pulse, long_press, repeat_pulse, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                bad++;
                $display("FAIL two_keys t=%0d got=%b want=%b", t,
                         {press, release_pulse, long_press, repeat_pulse, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
            if (t == 0) begin
                total++;
                if (press !== 2'b11) begin
                    bad++;
                    $display("FAIL two_keys_press got=%b want=11", press);
                end
            end
            if (t == 3) begin
                total++;
                if (release_pulse !== 2'b10) begin
                    bad++;
                    $display("FAIL two_keys_release1 got=%b want=10", release_pulse);
                end
            end
            n_long0 += int'(long_press[0]);
        end
        total++;
        if (n_long0 != 1) begin
            bad++;
            $display("FAIL two_keys_long0 count=%0d want=1", n_long0);
        end
    endtask

    task automatic test_reset_mid_hold();
        for (int t = 0; t <= 10; t++) cyc(2'b01);
        reset = 1'b1;
        #1;
        total++;
        if ({press, release_pulse, long_press, repeat_pulse, held} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async got=%b want=0", {press, release_pulse, long_press, repeat_pulse, held});
        end
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if ({press, release_pulse, long_press, repeat_pulse, held} !== '0) begin
            bad++;
            $display("FAIL reset_mid_held got=%b want=0", {press, release_pulse, long_press, repeat_pulse, held});
        end
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            cyc((t < 10) ? 2'b01 : 2'b00);
            total++;
            if ({press, release_pulse, long_press, repeat_pulse, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                bad++;
                $display("FAIL reset_mid_after t=%0d got=%b want=%b", t,
                         {press, release_pulse, long_press, repeat_pulse, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
            if (t == 0) begin
                total++;
                if (press[0] !== 1'b1 || release_pulse[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid_repress press=%b release=%b want 1 0", press[0], release_pulse[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] k = '0;
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 9) == 0) k[i] = ~k[i];
            cyc(k);
            total++;
            if ({press, release_pulse, long_press, repeat_pulse, held} !== {e_press, e_rel, e_long, e_rep, e_held}) begin
                bad++;
                $display("FAIL random t=%0d key=%b got=%b want=%b", t, k,
                         {press, release_pulse, long_press, repeat_pulse, held}, {e_press, e_rel, e_long, e_rep, e_held});
            end
        end
        cyc('0);
        cyc('0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_long_hold();
        test_short_hold(7, "hold7");
        test_short_hold(8, "hold8");
        test_two_keys();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
